// File: rtl/stream_mux_pkg.sv
// Shared types and defaults for the stream multiplexer.
// The STREAM_MUX_STATS_EN build option uses STATS_W as the handshake counter width.
package stream_mux_pkg;

  typedef enum logic {
    SELECT      = 1'b0,
    ROUND_ROBIN = 1'b1
  } mux_mode_e;

  localparam int NUM_CH_DEF = 4;
  localparam int DATA_W_DEF = 2;
  localparam int STATS_W    = 16;

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin grant search: first requester strictly after last_grant, wrapping to 0.
module rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] last_grant,
  output logic [$clog2(NUM_CH)-1:0] grant_idx,
  output logic                      grant_vld
);

  localparam int IDX_W = $clog2(NUM_CH);

  int cand;

  // Offsets 1..NUM_CH make last_grant itself the lowest-priority candidate.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = (int'(last_grant) + i) % NUM_CH;
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 stream multiplexer with a single output register, in either SELECT or ROUND_ROBIN mode.
// Define STREAM_MUX_STATS_EN to add the saturating handshake counter output xfer_cnt.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  in_data,
  input  logic [NUM_CH-1:0]              in_valid,
  output logic [NUM_CH-1:0]              in_ready,
  input  logic [$clog2(NUM_CH)-1:0]      sel,
  input  logic                           mode,
  output logic [DATA_W-1:0]              out_data,
  output logic                           out_valid,
  output logic [$clog2(NUM_CH)-1:0]      out_ch,
  input  logic                           out_ready
`ifdef STREAM_MUX_STATS_EN
  ,
  output logic [STATS_W-1:0]             xfer_cnt
`endif
);

  localparam int SEL_W = $clog2(NUM_CH);

  mux_mode_e        mode_e;
  logic [SEL_W-1:0] last_grant;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_vld;
  logic             sel_req;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_vld;
  logic             load;
  logic             xfer;

  assign mode_e = mux_mode_e'(mode);
  assign load   = !out_valid || out_ready;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req        (in_valid),
    .last_grant (last_grant),
    .grant_idx  (rr_idx),
    .grant_vld  (rr_vld)
  );

  // The loop doubles as the sel < NUM_CH guard for non-power-of-two channel counts.
  always_comb begin
    sel_req = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (SEL_W'(i) == sel) begin
        sel_req = in_valid[i];
      end
    end
  end

  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    in_ready  = '0;
    if (mode_e == ROUND_ROBIN) begin
      grant_idx = rr_idx;
      grant_vld = rr_vld;
    end else begin
      grant_idx = sel;
      grant_vld = sel_req;
    end
    if (load && grant_vld && !rst) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  assign xfer = load && grant_vld;

  // A granted channel is always valid, so load && grant is the input handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      last_grant <= SEL_W'(NUM_CH - 1);
    end else if (xfer) begin
      out_valid  <= 1'b1;
      out_data   <= in_data[grant_idx];
      out_ch     <= grant_idx;
      last_grant <= grant_idx;
    end else if (load) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef STREAM_MUX_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready && (xfer_cnt != {STATS_W{1'b1}})) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed self-checking bench for stream_mux_rr (NUM_CH=4, DATA_W=2), driven through stream_mux_if.
// Covers the STREAM_MUX_STATS_EN counter when that macro is defined.
interface stream_mux_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 2
) (
  input logic clk
);
  logic                          rst;
  logic [NUM_CH-1:0][DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]             in_valid;
  logic [NUM_CH-1:0]             in_ready;
  logic [$clog2(NUM_CH)-1:0]     sel;
  logic                          mode;
  logic [DATA_W-1:0]             out_data;
  logic                          out_valid;
  logic [$clog2(NUM_CH)-1:0]     out_ch;
  logic                          out_ready;
`ifdef STREAM_MUX_STATS_EN
  logic [15:0]                   xfer_cnt;
`endif
endinterface

module tb_stream_mux_rr;

  logic clk = 1'b0;
  int   checkCount = 0;
  int   failCount  = 0;

  always #5 clk = ~clk;

  stream_mux_if #(.NUM_CH(4), .DATA_W(2)) vif (.clk(clk));

  stream_mux_rr #(
    .NUM_CH (4),
    .DATA_W (2)
  ) dut (
    .clk       (vif.clk),
    .rst       (vif.rst),
    .in_data   (vif.in_data),
    .in_valid  (vif.in_valid),
    .in_ready  (vif.in_ready),
    .sel       (vif.sel),
    .mode      (vif.mode),
    .out_data  (vif.out_data),
    .out_valid (vif.out_valid),
    .out_ch    (vif.out_ch),
    .out_ready (vif.out_ready)
`ifdef STREAM_MUX_STATS_EN
    ,
    .xfer_cnt  (vif.xfer_cnt)
`endif
  );

  task automatic applyStimulus(input logic m, input logic [1:0] s, input logic [3:0] v,
                               input logic [7:0] d, input logic ordy);
    vif.mode      = m;
    vif.sel       = s;
    vif.in_valid  = v;
    vif.in_data   = d;
    vif.out_ready = ordy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOut(input string tag, input logic v, input logic [1:0] d,
                          input logic [1:0] ch);
    checkOutput({tag, "_valid"}, 32'(vif.out_valid), 32'(v));
    checkOutput({tag, "_data"},  32'(vif.out_data),  32'(d));
    checkOutput({tag, "_ch"},    32'(vif.out_ch),    32'(ch));
  endtask

  // Five RR cycles with all channels valid: expected grant order 0,1,2,3,0.
  logic [1:0] rrExp [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    vif.rst = 1'b1;
    applyStimulus(1'b1, 2'd0, 4'b1111, 8'hE4, 1'b1);
    #2;
    checkOut("reset", 1'b0, 2'd0, 2'd0);
    checkOutput("reset_in_ready", 32'(vif.in_ready), 32'h0);
    tick();
    checkOutput("reset_in_ready_edge", 32'(vif.in_ready), 32'h0);
    vif.rst = 1'b0;
    applyStimulus(1'b0, 2'd2, 4'b0100, 8'b00_11_01_10, 1'b1);
    #1;
    checkOutput("sel_in_ready", 32'(vif.in_ready), 32'b0100);
    tick();
    checkOut("sel_load", 1'b1, 2'd3, 2'd2);

    applyStimulus(1'b0, 2'd1, 4'b0100, 8'b00_11_01_10, 1'b1);
    #1;
    checkOutput("sel_invalid_in_ready", 32'(vif.in_ready), 32'h0);
    tick();
    checkOut("sel_empty_hold", 1'b0, 2'd3, 2'd2);

    vif.rst = 1'b1;
    tick();
    vif.rst = 1'b0;
    applyStimulus(1'b1, 2'd0, 4'b1111, 8'b11_10_01_00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput($sformatf("rr_in_ready_%0d", i), 32'(vif.in_ready), 32'(4'b0001 << rrExp[i]));
      tick();
      checkOut($sformatf("rr_out_%0d", i), 1'b1, rrExp[i], rrExp[i]);
    end

    applyStimulus(1'b1, 2'd0, 4'b1111, 8'b11_10_01_00, 1'b0);
    #1;
    checkOutput("stall_in_ready", 32'(vif.in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      vif.in_data = (i == 2) ? 8'b00_01_10_11 : 8'(8'h5A + i);
      vif.mode    = 1'(i);
      tick();
      vif.mode    = 1'b1;
      #1;
      checkOut($sformatf("stall_%0d", i), 1'b1, 2'd0, 2'd0);
      checkOutput($sformatf("stall_in_ready_%0d", i), 32'(vif.in_ready), 32'h0);
    end
    vif.out_ready = 1'b1;
    #1;
    checkOutput("release_in_ready", 32'(vif.in_ready), 32'b0010);
    tick();
    checkOut("release", 1'b1, 2'd2, 2'd1);

    applyStimulus(1'b1, 2'd0, 4'b1000, 8'b00_01_10_11, 1'b1);
    tick();
    checkOut("to_ch3", 1'b1, 2'd0, 2'd3);
    applyStimulus(1'b1, 2'd0, 4'b0010, 8'b00_01_10_11, 1'b1);
    #1;
    checkOutput("wrap_in_ready", 32'(vif.in_ready), 32'b0010);
    tick();
    checkOut("wrap", 1'b1, 2'd2, 2'd1);
    applyStimulus(1'b1, 2'd0, 4'b0011, 8'b00_01_10_11, 1'b1);
    #1;
    checkOutput("wrap2_in_ready", 32'(vif.in_ready), 32'b0001);
    tick();
    checkOut("wrap2", 1'b1, 2'd3, 2'd0);

    applyStimulus(1'b1, 2'd0, 4'b1111, 8'b11_10_01_00, 1'b1);
    tick();
    checkOut("pre_rst", 1'b1, 2'd1, 2'd1);
    vif.rst = 1'b1;
    #1;
    checkOut("async_rst", 1'b0, 2'd0, 2'd0);
    checkOutput("async_rst_in_ready", 32'(vif.in_ready), 32'h0);
    tick();
    vif.rst = 1'b0;
    applyStimulus(1'b1, 2'd0, 4'b0110, 8'b11_10_01_00, 1'b1);
    #1;
    checkOutput("post_rst_in_ready", 32'(vif.in_ready), 32'b0010);
    vif.in_valid = 4'b1111;
    #1;
    checkOutput("post_rst_in_ready_all", 32'(vif.in_ready), 32'b0001);
    tick();
    checkOut("post_rst", 1'b1, 2'd0, 2'd0);

`ifdef STREAM_MUX_STATS_EN
    vif.rst = 1'b1;
    tick();
    vif.rst = 1'b0;
    checkOutput("cnt_reset", 32'(vif.xfer_cnt), 32'h0);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("cnt_10", 32'(vif.xfer_cnt), 32'd9);
    for (int i = 0; i < 70000; i++) tick();
    checkOutput("cnt_sat", 32'(vif.xfer_cnt), 32'hFFFF);
    vif.rst = 1'b1;
    #1;
    checkOutput("cnt_clear", 32'(vif.xfer_cnt), 32'h0);
    tick();
    vif.rst = 1'b0;
`endif

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of input channels (2..16).
REQ-002 SHALL have parameter DATA_W, default 2, payload width per channel (1..32).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_data  input  NUM_CH x DATA_W  per-channel payload.
REQ-006 SHALL have port in_valid  input  NUM_CH  per-channel valid.
REQ-007 SHALL have port in_ready  output  NUM_CH  per-channel ready, one-hot or zero.
REQ-008 SHALL have port sel  input  $clog2(NUM_CH)  channel to forward in SELECT mode.
REQ-009 SHALL have port mode  input  1  0 = SELECT, 1 = ROUND_ROBIN.
REQ-010 SHALL have port out_data  output  DATA_W  registered payload.
REQ-011 SHALL have port out_valid  output  1  registered valid.
REQ-012 SHALL have port out_ch  output  $clog2(NUM_CH)  source channel of out_data.
REQ-013 SHALL have port out_ready  input  1  downstream ready.

Function
REQ-014 Load condition SHALL be load = !out_valid || out_ready.
REQ-015 SELECT: grant SHALL be sel when in_valid[sel]=1 and sel<NUM_CH; otherwise no grant.
REQ-016 ROUND_ROBIN: grant SHALL be the first valid channel searching upward from (last_grant+1) mod NUM_CH, wrapping at NUM_CH-1 -> 0.
REQ-017 in_ready[g] SHALL be 1 only when load=1 and g is the granted channel; a transfer occurs when in_valid[g] && in_ready[g].
REQ-018 On transfer, out_data, out_ch SHALL capture the granted channel's data/index and out_valid SHALL be 1 the next cycle (latency 1).
REQ-019 When load=1 and no grant, out_valid SHALL go 0 next cycle; out_data/out_ch SHALL hold.
REQ-020 While out_valid=1 and out_ready=0, out_data, out_ch, out_valid SHALL stay stable and all in_ready SHALL be 0.
REQ-021 Back-to-back transfers SHALL sustain one per cycle while out_ready=1.
REQ-022 last_grant SHALL update only on a transfer, in both modes.
REQ-023 mode/sel changes SHALL affect only the next arbitration, never a held output.
REQ-024 in_ready SHALL depend combinationally on in_valid, sel, mode, out_ready and registered state only.

Reset
REQ-025 rst=1 SHALL asynchronously force out_valid=0, out_data=0, out_ch=0, last_grant=NUM_CH-1.
REQ-026 During reset all in_ready SHALL be 0; a held output is discarded.
REQ-027 After rst deasserts, the first ROUND_ROBIN grant SHALL search from channel 0.

Configuration
REQ-028 Macro STREAM_MUX_STATS_EN SHALL, when defined, add output xfer_cnt (16 bits) counting output handshakes (out_valid && out_ready), saturating at 16'hFFFF, reset to 0.
REQ-029 Without STREAM_MUX_STATS_EN, port xfer_cnt and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-030 Package stream_mux_pkg SHALL hold typedef enum mux_mode_e {SELECT, ROUND_ROBIN}, defaults NUM_CH_DEF=4, DATA_W_DEF=2, and STATS_W=16.
REQ-031 The grant search SHALL be a sub-module rr_arbiter (inputs req, last_grant; output grant_idx, grant_vld).
REQ-032 The bench SHALL drive all ports through an interface instance, as done for existing mux benches.

Verification (NUM_CH=4, DATA_W=2)
REQ-033 SELECT, sel=2, in_valid=4'b0100, in_data[2]=2'b11, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=3, out_ch=2.
REQ-034 ROUND_ROBIN, in_valid=4'b1111 for 5 cycles, out_ready=1 -> out_ch sequence 0,1,2,3,0.
REQ-035 Output valid with out_ready=0 for 3 cycles, in_data changing -> out_data/out_ch frozen, in_ready=0; on out_ready=1 next grant loads.
REQ-036 ROUND_ROBIN, last_grant=3, in_valid=4'b0010 -> grant channel 1 (wrap); then in_valid=4'b0011 -> grant 0.
REQ-037 rst pulsed mid-stream with out_valid=1 -> out_valid=0 immediately (no clock edge), first later ROUND_ROBIN grant from channel 0.
REQ-038 STREAM_MUX_STATS_EN defined, 70000 handshakes -> xfer_cnt=16'hFFFF; after rst xfer_cnt=0.
